// File: rtl/grf_regfile.sv
// rtl/grf_regfile.sv - 32 x 32 MIPS register file, two async reads, one sync write, $0 hardwired to zero.
// Optional macro GRF_BYPASS_EN forwards same-cycle write data onto the read ports.
module grf_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    input  logic [AW-1:0] WA,
    input  logic [DW-1:0] WD,
    input  logic          WE,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2
);

    localparam int NREG = 2 ** AW;

    // Index 0 is never declared: $0 has no storage at all.
    logic [DW-1:0] regs_q [1:NREG-1];
    logic [DW-1:0] regs_d [1:NREG-1];

    logic wr_hit;
    assign wr_hit = WE && (WA != '0);

    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            // WE gates first so unknown WA/WD cannot leak in while writes are disabled.
            if (wr_hit && (WA == AW'(i))) begin
                regs_d[i] = WD;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    logic [DW-1:0] arr_rd1;
    logic [DW-1:0] arr_rd2;

    always_comb begin
        arr_rd1 = '0;
        arr_rd2 = '0;
        for (int i = 1; i < NREG; i++) begin
            if (RA1 == AW'(i)) arr_rd1 = regs_q[i];
            if (RA2 == AW'(i)) arr_rd2 = regs_q[i];
        end
    end

`ifdef GRF_BYPASS_EN
    // WB and ID share a cycle in the pipelined datapath, so the value being written is forwarded.
    always_comb begin
        RD1 = (wr_hit && (RA1 == WA)) ? WD : arr_rd1;
        RD2 = (wr_hit && (RA2 == WA)) ? WD : arr_rd2;
    end
`else
    always_comb begin
        RD1 = arr_rd1;
        RD2 = arr_rd2;
    end
`endif

endmodule

// File: doc/grf_regfile.md
Name: grf_regfile

Overview:
- 32 x 32-bit general register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU: RD1 drives ALU operand A; RD2 drives operand B, or the memory store data.
- Takes its write-back from the ALU result or the memory load mux.
- Two combinational read ports, one synchronous write port; register $0 is hardwired to zero.

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; register count is 2**AW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears the register array.
- RA1  input  AW  read address, port 1 (instruction rs field).
- RA2  input  AW  read address, port 2 (instruction rt field).
- WA  input  AW  write address (rd / rt / 31, selected upstream).
- WD  input  DW  write data (ALU result, load data or PC+4).
- WE  input  1  write enable (RegWrite from the controller).
- RD1  output  DW  read data, port 1.
- RD2  output  DW  read data, port 2.

Behaviour:
- Storage: registers 1..2**AW-1 are flops. Register 0 has no storage.
- Reset: reset_n low clears every register to 32'h0000_0000 immediately, with no clock required.
  - While reset_n is low, RD1 and RD2 read 0 for every address.
  - Reset takes priority over any write in progress; a write whose edge coincides with reset_n low is dropped.
  - After reset_n rises, the first write is taken on the next rising clk edge.
- Write: on a rising clk edge with WE=1 and WA!=0, register[WA] <= WD.
  - WE=0 leaves the array unchanged.
  - WA=0 is ignored regardless of WE; $0 stays 0.
- Read: RD1/RD2 are combinational from RA1/RA2 with zero cycles of latency.
  - RA=0 always returns 0.
  - RA1 and RA2 may be equal; both ports then return the same value.
- Same-cycle read/write hazard: RA equals WA, WE=1 and WA!=0 in the same cycle.
  - Baseline behaviour: the read returns the old contents. The new value is visible from the cycle after the edge.
  - With the optional feature, see below.
- Width rules: WD is stored unmodified, with no sign or zero extension in this block. Addresses are used modulo 2**AW.
- X-safety: with WE=0, unknown WA/WD must not corrupt the array.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined: internal write-to-read forwarding.
  - If WE=1, WA!=0 and RA1==WA, then RD1=WD combinationally; RD2 likewise for RA2.
  - The array still updates at the edge as normal.
  - Used when the file is reused in the pipelined P5 datapath, where WB and ID share a cycle.
- Not defined: no forwarding. Reads always return the current array contents, which is the single-cycle P4 behaviour.

Test Plan:
- Reset: hold reset_n=0 mid-cycle after writes, with RA1=5 and RA2=31 -> RD1=RD2=0 immediately, without waiting for a clk edge; all 32 registers read back 0 after release.
- Basic write/read: WE=1, WA=8, WD=32'hDEAD_BEEF at an edge; next cycle RA1=8 -> RD1=32'hDEAD_BEEF, and RA2=9 -> RD2=0.
- $0 protection: WE=1, WA=0, WD=32'hFFFF_FFFF at an edge; then RA1=RA2=0 -> RD1=RD2=0.
- Write disable: preload reg 3=32'h0000_1234; apply WE=0, WA=3, WD=32'h5555_5555 at an edge -> RA1=3 still reads 32'h0000_1234.
- Same-cycle hazard: reg 4=32'h0000_0001; WE=1, WA=4, WD=32'h0000_0002, RA1=RA2=4.
  - Before the edge: RD1=RD2=32'h0000_0001 without the macro; 32'h0000_0002 with GRF_BYPASS_EN.
  - After the edge: both configurations read 32'h0000_0002.
- Reset vs write race: assert reset_n=0 together with a WE=1, WA=7, WD=32'h0000_00AA edge; release reset_n -> RA1=7 reads 0.
